// File: rtl/traffic_pkg.sv
// Shared light codes, state encodings and a small
// constant helper for the parametrised intersection controller.
package traffic_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  localparam logic [2:0] MG   = 3'd0;
  localparam logic [2:0] MY   = 3'd1;
  localparam logic [2:0] AR1  = 3'd2;
  localparam logic [2:0] SG   = 3'd3;
  localparam logic [2:0] SY   = 3'd4;
  localparam logic [2:0] AR2  = 3'd5;
  localparam logic [2:0] WALK = 3'd6;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-clock tick per second; clr restarts
// the second so every phase begins on a whole-second boundary.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick,
  output logic half,
  output logic [$clog2(TICKS_PER_SEC)-1:0] count
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] MID  = PW'(TICKS_PER_SEC / 2);

  assign tick = (count == LAST);
  assign half = (count < MID);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_controller_param.sv
// Main/side intersection controller with parametrised phase times,
// optional all-red clearance, blinking walk tail and request latch.
module traffic_controller_param
  import traffic_pkg::*;
#(
  parameter int TICKS_PER_SEC    = 100000000,
  parameter int MAIN_GREEN_LONG  = 12,
  parameter int MAIN_GREEN_SHORT = 9,
  parameter int SIDE_GREEN       = 6,
  parameter int SIDE_GREEN_EXT   = 9,
  parameter int YELLOW_TIME      = 2,
  parameter int ALL_RED_TIME     = 1,
  parameter int WALK_TIME        = 3,
  parameter int WALK_BLINK       = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       ss,
  output logic [1:0] ml,
  output logic [1:0] sl,
  output logic       wl,
  output logic       ped_ack,
  output logic [2:0] state_o
);

  localparam int MAXD = max_of(
    max_of(max_of(MAIN_GREEN_LONG, MAIN_GREEN_SHORT),
           max_of(SIDE_GREEN, SIDE_GREEN_EXT)),
    max_of(max_of(YELLOW_TIME, ALL_RED_TIME), WALK_TIME));
  localparam int CW = $clog2(MAXD) + 1;
  localparam int PW = $clog2(TICKS_PER_SEC);

  localparam logic [CW-1:0] D_ML  = CW'(MAIN_GREEN_LONG);
  localparam logic [CW-1:0] D_MS  = CW'(MAIN_GREEN_SHORT);
  localparam logic [CW-1:0] D_SG  = CW'(SIDE_GREEN);
  localparam logic [CW-1:0] D_SGE = CW'(SIDE_GREEN_EXT);
  localparam logic [CW-1:0] D_Y   = CW'(YELLOW_TIME);
  localparam logic [CW-1:0] D_AR  = CW'(ALL_RED_TIME);
  localparam logic [CW-1:0] D_W   = CW'(WALK_TIME);
  localparam logic [CW-1:0] DP    = CW'(SIDE_GREEN - 1);
  localparam logic [CW-1:0] SOLID = CW'(WALK_TIME - WALK_BLINK);
  localparam bit NO_AR = (ALL_RED_TIME == 0);

  logic [2:0]    state, nxt;
  logic [CW-1:0] sec_cnt, dur;
  logic [PW-1:0] frac_unused;
  logic          tick, half, chg, done;
  logic          at_dp, ext_flag, ext_eff, latch;

  sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_pre (
    .clk   (clk),
    .reset (reset),
    .clr   (chg),
    .tick  (tick),
    .half  (half),
    .count (frac_unused)
  );

  // ss is live only on the decision-point second of a green phase
  assign at_dp   = (state == MG || state == SG) && (sec_cnt == DP);
  assign ext_eff = at_dp ? ss : ext_flag;

  always_comb begin
    dur = D_ML;
    case (state)
      MG:       dur = ext_eff ? D_MS : D_ML;
      MY, SY:   dur = D_Y;
      AR1, AR2: dur = D_AR;
      SG:       dur = ext_eff ? D_SGE : D_SG;
      WALK:     dur = D_W;
      default:  dur = D_ML;
    endcase
  end

  assign done = tick && (sec_cnt == dur - 1'b1);

  always_comb begin
    nxt = state;
    if (done) begin
      case (state)
        MG:      nxt = MY;
        MY:      nxt = NO_AR ? (latch ? WALK : SG) : AR1;
        AR1:     nxt = latch ? WALK : SG;
        WALK:    nxt = SG;
        SG:      nxt = SY;
        SY:      nxt = NO_AR ? MG : AR2;
        AR2:     nxt = MG;
        default: nxt = MG;
      endcase
    end
  end

  assign chg = (nxt != state);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MG;
      sec_cnt  <= '0;
      ext_flag <= 1'b0;
      latch    <= 1'b0;
    end else begin
      state <= nxt;
      if (chg) begin
        sec_cnt  <= '0;
        ext_flag <= 1'b0;
      end else if (tick) begin
        sec_cnt <= sec_cnt + 1'b1;
        if (at_dp) ext_flag <= ss;
      end
      if (chg && nxt == WALK) begin
        latch <= 1'b0;
      end else if (req && state != WALK) begin
        latch <= 1'b1;
      end
    end
  end

  always_comb begin
    ml = RED;
    sl = RED;
    wl = 1'b0;
    unique case (1'b1)
      (state == MG):   ml = GREEN;
      (state == MY):   ml = YELLOW;
      (state == SG):   sl = GREEN;
      (state == SY):   sl = YELLOW;
      (state == WALK): wl = (sec_cnt < SOLID) || half;
      default:         ml = RED;
    endcase
  end

  assign ped_ack = latch;
  assign state_o = state;

endmodule

// File: tb/tb_traffic_controller_param.sv
// Bench for traffic_controller_param: cycle-level phase model plus
// directed phase-length, walk-pattern and reset checks.
module tb_traffic_controller_param;

  localparam int T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req = 1'b0;
  logic ss = 1'b0;
  logic [1:0] ml, sl;
  logic wl, ped_ack;
  logic [2:0] state_o;

  logic rst0 = 1'b1;
  logic req0 = 1'b0;
  logic ss0 = 1'b0;
  logic [1:0] ml0, sl0;
  logic wl0, ack0;
  logic [2:0] state0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_controller_param #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .reset(reset), .req(req), .ss(ss),
    .ml(ml), .sl(sl), .wl(wl), .ped_ack(ped_ack),
    .state_o(state_o)
  );

  traffic_controller_param #(.TICKS_PER_SEC(T), .ALL_RED_TIME(0)) dut0 (
    .clk(clk), .reset(rst0), .req(req0), .ss(ss0),
    .ml(ml0), .sl(sl0), .wl(wl0), .ped_ack(ack0),
    .state_o(state0)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: phase code, cycles spent in it, sampled extension, request
  int m_ph = 0;
  int m_cyc = 0;
  bit m_ext = 0;
  bit m_lat = 0;

  function automatic int secs_of(input int ph, input bit e);
    case (ph)
      0: return e ? 9 : 12;
      1, 4: return 2;
      2, 5: return 1;
      3: return e ? 9 : 6;
      default: return 3;
    endcase
  endfunction

  function automatic int follow(input int ph, input bit lat);
    case (ph)
      0: return 1;
      1: return 2;
      2: return lat ? 6 : 3;
      6: return 3;
      3: return 4;
      4: return 5;
      default: return 0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_ph = 0; m_cyc = 0; m_ext = 0; m_lat = 0;
      end else begin
        automatic bit e;
        automatic bit ln;
        automatic int np;
        e = (m_cyc == 6 * T - 1 && (m_ph == 0 || m_ph == 3)) ? ss : m_ext;
        ln = m_lat | (req && m_ph != 6);
        if (m_cyc == secs_of(m_ph, e) * T - 1) begin
          np = follow(m_ph, m_lat);
          m_ph = np; m_cyc = 0; m_ext = 0;
          if (np == 6) ln = 0;
        end else begin
          m_cyc++;
          m_ext = e;
        end
        m_lat = ln;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        automatic int eml, esl, ewl;
        eml = 2; esl = 2; ewl = 0;
        case (m_ph)
          0: eml = 0;
          1: eml = 1;
          3: esl = 0;
          4: esl = 1;
          6: ewl = (m_cyc < 2 * T || (m_cyc % T) < T / 2) ? 1 : 0;
          default: ;
        endcase
        chk("model_state", int'(state_o), m_ph);
        chk("model_ml", int'(ml), eml);
        chk("model_sl", int'(sl), esl);
        chk("model_wl", int'(wl), ewl);
        chk("model_ack", int'(ped_ack), int'(m_lat));
      end
    end
  end

  // Run-length and walk-light recorders for the main instance
  int st_q[$];
  int len_q[$];
  int wl_q[$];
  initial begin
    automatic int prev = -1;
    automatic int run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = -1; run = 0;
      end else begin
        if (prev >= 0 && int'(state_o) != prev) begin
          st_q.push_back(prev);
          len_q.push_back(run);
          run = 0;
        end
        run++;
        prev = int'(state_o);
        if (state_o == 3'd6) wl_q.push_back(int'(wl));
      end
    end
  end

  task automatic wait_state(input logic [2:0] s, input int budget);
    automatic int n = 0;
    while (state_o != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (state_o != s) begin
      checks++;
      errors++;
      $display("FAIL wait_state: got %0d expected %0d", state_o, s);
    end
  endtask

  task automatic count_run0(input logic [2:0] s, output int n);
    n = 0;
    while (state0 == s && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  int exp_st[30] = '{0,1,2,3,4,5, 0,1,2,3,4,5,
                     0,1,2,3,4,5, 0,1,2,6,3,4,5, 0,1,2,6,3};
  int exp_len[30] = '{48,8,4,24,8,4, 36,8,4,36,8,4,
                      48,8,4,24,8,4, 48,8,4,12,24,8,4, 48,8,4,12,24};
  int exp_wl[12] = '{1,1,1,1,1,1,1,1,1,1,0,0};

  initial begin
    automatic int n;
    #1;
    chk("reset_ml", int'(ml), 0);
    chk("reset_sl", int'(sl), 2);
    chk("reset_wl", int'(wl), 0);
    chk("reset_ack", int'(ped_ack), 0);
    chk("reset_state", int'(state_o), 0);

    @(posedge clk);
    #3 reset = 1'b0;

    wait_state(3'd5, 200);
    wait_state(3'd0, 50);
    ss = 1'b1;
    wait_state(3'd4, 300);
    ss = 1'b0;
    wait_state(3'd0, 50);
    repeat (12) @(negedge clk);
    ss = 1'b1;
    repeat (4) @(negedge clk);
    ss = 1'b0;

    wait_state(3'd3, 200);
    repeat (2) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("ack_after_pulse", int'(ped_ack), 1);
    wait_state(3'd6, 400);
    chk("ack_walk_entry", int'(ped_ack), 0);
    chk("ml_walk_entry", int'(ml), 2);

    wait_state(3'd3, 50);
    req = 1'b1;
    wait_state(3'd6, 400);
    repeat (6) @(negedge clk);
    chk("ack_walk_held", int'(ped_ack), 0);
    wait_state(3'd3, 50);
    repeat (2) @(negedge clk);
    chk("ack_sg_reset", int'(ped_ack), 1);
    req = 1'b0;
    wait_state(3'd4, 200);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      if (i < st_q.size()) begin
        chk($sformatf("run%0d_state", i), st_q[i], exp_st[i]);
        chk($sformatf("run%0d_len", i), len_q[i], exp_len[i]);
      end else begin
        chk($sformatf("run%0d_missing", i), st_q.size(), 30);
      end
    end
    for (int i = 0; i < 12; i++) begin
      if (i < wl_q.size()) chk($sformatf("walk_wl%0d", i), wl_q[i], exp_wl[i]);
      else chk("walk_wl_missing", wl_q.size(), 12);
    end

    @(posedge clk);
    #3 rst0 = 1'b0;
    @(negedge clk);
    count_run0(3'd0, n);
    chk("nar_mg_len", n, 48);
    count_run0(3'd1, n);
    chk("nar_my_len", n, 8);
    chk("nar_my_to_sg", int'(state0), 3);
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    chk("nar_ack", int'(ack0), 1);
    count_run0(3'd3, n);
    chk("nar_sg_rest", n, 23);
    @(negedge clk);
    chk("nar_sy_sl", int'(sl0), 1);
    chk("nar_sy_ack", int'(ack0), 1);
    rst0 = 1'b1;
    #1;
    chk("midsy_reset_ml", int'(ml0), 0);
    chk("midsy_reset_sl", int'(sl0), 2);
    chk("midsy_reset_wl", int'(wl0), 0);
    chk("midsy_reset_ack", int'(ack0), 0);
    chk("midsy_reset_state", int'(state0), 0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
